multiply_control: RTL and testbench
===================================

# multiply_control

Sequencing FSM for the shift-add signed multiplier datapath. Drives the two shift registers (A, B), the X sign flip-flop and the adder/subtractor. It issues clear, load, add/subtract and shift strobes for exactly N add/shift iterations per Run press. The final iteration subtracts the multiplicand, giving a two's-complement result in X:A:B. It sits between the debounced switch/button inputs and the register/adder datapath.

## Interface
- N, 8, operand width and number of add/shift iterations (2..16).
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low (0 = reset); clears all state immediately.
- Run  in  1  start request, level, synchronous and debounced; start is its 0->1 transition.
- ClearA_LoadB  in  1  level request: clear X/A and load B from switches; honoured only in IDLE.
- M  in  1  current multiplier bit (B[0]), sampled combinationally in ADD.
- Ld_B  out  1  load B from switch bus.
- ClearXA  out  1  synchronous clear of X and A.
- Ld_A  out  1  load adder result into A.
- Ld_X  out  1  load adder sign bit into X.
- Add_En  out  1  adder computes A + S.
- Sub_En  out  1  adder computes A - S.
- Shift_En  out  1  arithmetic right shift of X:A:B.
- Busy  out  1  high from CLR through the last SHIFT.
- Done  out  1  high in DONE.

## Operation
- States: IDLE, CLR, ADD, SHIFT, DONE. Iteration counter cnt, width ceil(log2 N), range 0..N-1.
- Run edge detector: register run_q holds the previous Run. start = Run & ~run_q.
- IDLE: Busy=0, Done=0.
  - start=1 -> CLR.
  - Else if ClearA_LoadB=1: Ld_B=1 and ClearXA=1 for every cycle it is held. Stay in IDLE.
- CLR: ClearXA=1, Busy=1, cnt<=0, -> ADD.
- ADD: Busy=1.
  - If M=1 and cnt<N-1: Add_En=Ld_A=Ld_X=1.
  - If M=1 and cnt==N-1: Sub_En=Ld_A=Ld_X=1.
  - If M=0: no strobe.
  - Always -> SHIFT, so latency is fixed and independent of operand value.
- SHIFT: Shift_En=1, Busy=1.
  - cnt<N-1: cnt<=cnt+1, -> ADD.
  - cnt==N-1: -> DONE (cnt stays, no wrap past N-1).
- DONE: Done=1, all strobes 0. Stay until Run=0, then -> IDLE. Holding Run never restarts.
- Outputs decode from state. M enters only in ADD (Mealy). All strobes are mutually exclusive except Ld_A/Ld_X with Add_En or Sub_En, and Ld_B with ClearXA.
- Add_En and Sub_En are never high in the same cycle.
- ClearA_LoadB is ignored in CLR, ADD, SHIFT and DONE.

## Timing
- Reset=0 (any time, including mid-multiply): state=IDLE, cnt=0, run_q=1. All outputs 0 asynchronously.
  - run_q=1 means Run must be seen low once after reset before a start is accepted.
- Start latency: Run rises in cycle t (IDLE) -> ClearXA in t+1, first ADD in t+2.
- Multiply length: 1 + 2N cycles of Busy (17 for N=8). Done asserts the cycle after the last Shift_En.
- Strobe pattern: ADD/SHIFT alternate strictly. Exactly N Shift_En pulses per run. At most one Sub_En per run, only in the last ADD.
- Run rising in the same IDLE cycle as ClearA_LoadB=1: start wins; Ld_B/ClearXA-from-load not issued that cycle.
- Run toggling while Busy: ignored. run_q still tracks Run, so a press held across DONE does not retrigger.

## Test plan
- Reset: drive Reset=0 mid-ADD with M=1 -> all outputs 0 immediately; after release, Run held high -> stays IDLE until Run 0->1.
- Load: IDLE, ClearA_LoadB=1 for 3 cycles -> Ld_B=ClearXA=1 for exactly 3 cycles, Busy=0.
- Full run N=8, M constant 1: Run 0->1 -> ClearXA at t+1, then 7 Add_En and 1 Sub_En, each followed by Shift_En. Busy for 17 cycles, Done at t+18.
- With the datapath: multiplicand 0x07, multiplier 0xFD (-3) -> A:B = 0xFFEB (-21). Operands 0x80 x 0x80 -> 0x4000.
- M=0 throughout: no Add_En/Sub_En/Ld_A, 8 Shift_En, same 17-cycle Busy.
- Run held through DONE, ClearA_LoadB pulsed mid-run -> no Ld_B. DONE persists until Run=0, then IDLE. Next press restarts with cnt=0.

Source files
------------

// File: rtl/multiply_control.sv
`default_nettype none
// ============================================================================
//  Module      : multiply_control
//  Description : Sequencing FSM for a shift-add signed multiplier datapath.
//                A start (0->1 edge on Run) clears X/A, then runs N strict
//                ADD/SHIFT pairs. On every ADD the current multiplier bit M
//                decides whether the multiplicand is accumulated into A.
//                The final ADD subtracts the multiplicand, so X:A:B ends up
//                holding the two's-complement product.
//
//  Ports
//    Clk          in   system clock, rising-edge
//    Reset        in   asynchronous active-low reset
//    Run          in   start request (level); start fires on its 0->1 edge
//    ClearA_LoadB in   IDLE-only request: clear X/A and load B
//    M            in   current multiplier bit B[0], used only in ADD
//    Ld_B         out  load B from the switch bus
//    ClearXA      out  synchronous clear of X and A
//    Ld_A         out  load adder result into A
//    Ld_X         out  load adder sign bit into X
//    Add_En       out  adder computes A + S
//    Sub_En       out  adder computes A - S
//    Shift_En     out  arithmetic right shift of X:A:B
//    Busy         out  high from CLR through the last SHIFT
//    Done         out  high while in DONE
//
//  Revision    : 1.0  initial release
// ============================================================================
module multiply_control #(
    parameter int N = 8                 // operand width / iterations, 2..16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Ld_B,
    output logic ClearXA,
    output logic Ld_A,
    output logic Ld_X,
    output logic Add_En,
    output logic Sub_En,
    output logic Shift_En,
    output logic Busy,
    output logic Done
);

    // Iteration counter spans 0..N-1.
    localparam int              CNT_W      = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_run_q;

    logic w_start;
    logic w_last;

    // Internal (ungated) strobes; the ports are these ANDed with Reset.
    logic w_ld_b;
    logic w_clear_xa;
    logic w_ld_a;
    logic w_ld_x;
    logic w_add_en;
    logic w_sub_en;
    logic w_shift_en;
    logic w_busy;
    logic w_done;

    // A start is the rising edge of Run. r_run_q resets high so that a Run
    // still held from before reset has to be released once before it counts.
    assign w_start = Run & ~r_run_q;
    assign w_last  = (r_cnt == C_CNT_LAST);

    // ------------------------------------------------------------------
    // State, counter and Run history
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_run_q <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            // Tracks Run in every state, so a press held across DONE
            // never looks like a fresh edge once IDLE is reached.
            r_run_q <= Run;
        end
    end

    // ------------------------------------------------------------------
    // Next state, counter update and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_ld_b       = 1'b0;
        w_clear_xa   = 1'b0;
        w_ld_a       = 1'b0;
        w_ld_x       = 1'b0;
        w_add_en     = 1'b0;
        w_sub_en     = 1'b0;
        w_shift_en   = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    // Start takes priority over a simultaneous load request.
                    w_next_state = S_CLR;
                end else if (ClearA_LoadB) begin
                    w_ld_b     = 1'b1;
                    w_clear_xa = 1'b1;
                end
            end

            S_CLR: begin
                w_clear_xa   = 1'b1;
                w_busy       = 1'b1;
                w_cnt_next   = '0;
                w_next_state = S_ADD;
            end

            S_ADD: begin
                w_busy = 1'b1;
                // Only the multiplier bit selects whether an accumulate
                // happens; the state sequence itself never depends on M,
                // so every multiply takes the same number of cycles.
                if (M) begin
                    w_ld_a = 1'b1;
                    w_ld_x = 1'b1;
                    if (w_last) begin
                        // Sign bit of the multiplier carries negative weight.
                        w_sub_en = 1'b1;
                    end else begin
                        w_add_en = 1'b1;
                    end
                end
                w_next_state = S_SHIFT;
            end

            S_SHIFT: begin
                w_busy     = 1'b1;
                w_shift_en = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_cnt_next   = r_cnt + C_CNT_ONE;
                    w_next_state = S_ADD;
                end
            end

            S_DONE: begin
                w_done = 1'b1;
                if (!Run) begin
                    w_next_state = S_IDLE;
                end
            end

            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs forced low for as long as Reset is held, independent of the
    // clock and of any combinational input (ClearA_LoadB, M).
    // ------------------------------------------------------------------
    assign Ld_B     = Reset & w_ld_b;
    assign ClearXA  = Reset & w_clear_xa;
    assign Ld_A     = Reset & w_ld_a;
    assign Ld_X     = Reset & w_ld_x;
    assign Add_En   = Reset & w_add_en;
    assign Sub_En   = Reset & w_sub_en;
    assign Shift_En = Reset & w_shift_en;
    assign Busy     = Reset & w_busy;
    assign Done     = Reset & w_done;

endmodule
`default_nettype wire

// File: tb/tb_multiply_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiply_control
//  Description : Directed self-checking bench for multiply_control, with a
//                small X:A:B shift-add datapath to check real products.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multiply_control;

    localparam int N = 8;

    // Expected output vectors, bit order:
    // {Ld_B, ClearXA, Ld_A, Ld_X, Add_En, Sub_En, Shift_En, Busy, Done}
    localparam logic [8:0] E_ZERO = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] E_LOAD = 9'b1_1_0_0_0_0_0_0_0;
    localparam logic [8:0] E_CLR  = 9'b0_1_0_0_0_0_0_1_0;
    localparam logic [8:0] E_ADD  = 9'b0_0_1_1_1_0_0_1_0;
    localparam logic [8:0] E_SUB  = 9'b0_0_1_1_0_1_0_1_0;
    localparam logic [8:0] E_NOP  = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] E_SHF  = 9'b0_0_0_0_0_0_1_1_0;
    localparam logic [8:0] E_DONE = 9'b0_0_0_0_0_0_0_0_1;

    logic Clk;
    logic Reset;
    logic Run;
    logic ClearA_LoadB;
    logic M;
    logic Ld_B, ClearXA, Ld_A, Ld_X, Add_En, Sub_En, Shift_En, Busy, Done;

    logic [8:0] obs;
    assign obs = {Ld_B, ClearXA, Ld_A, Ld_X, Add_En, Sub_En, Shift_En, Busy, Done};

    // Bench-side datapath
    logic       dp_mode;
    logic       m_force;
    logic [7:0] sw;
    logic [7:0] dp_a;
    logic [7:0] dp_b;
    logic       dp_x;
    logic [8:0] dp_sum;

    assign M = dp_mode ? dp_b[0] : m_force;

    always_comb begin
        if (Sub_En) dp_sum = {dp_a[7], dp_a} - {sw[7], sw};
        else        dp_sum = {dp_a[7], dp_a} + {sw[7], sw};
    end

    always_ff @(posedge Clk) begin
        if (ClearXA) begin
            dp_a <= 8'h00;
            dp_x <= 1'b0;
        end
        if (Ld_B) dp_b <= sw;
        if (Ld_A) dp_a <= dp_sum[7:0];
        if (Ld_X) dp_x <= dp_sum[8];
        if (Shift_En) begin
            dp_a <= {dp_x, dp_a[7:1]};
            dp_b <= {dp_a[0], dp_b[7:1]};
        end
    end

    multiply_control #(.N(N)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Ld_B         (Ld_B),
        .ClearXA      (ClearXA),
        .Ld_A         (Ld_A),
        .Ld_X         (Ld_X),
        .Add_En       (Add_En),
        .Sub_En       (Sub_En),
        .Shift_En     (Shift_En),
        .Busy         (Busy),
        .Done         (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    // Full multiply with constant M, checking every cycle's strobe pattern.
    task automatic run_const(input string tag, input logic mval, input bit disturb);
        dp_mode      = 1'b0;
        m_force      = mval;
        Run          = 1'b1;
        ClearA_LoadB = 1'b1;                   // start must beat the load
        #1 chk({tag, " start cycle"}, 32'(obs), 32'(E_ZERO));
        tick();
        chk({tag, " clr"}, 32'(obs), 32'(E_CLR));
        ClearA_LoadB = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (disturb && i == 2) Run = 1'b0;
            if (disturb && i == 3) ClearA_LoadB = 1'b1;
            if (disturb && i == 4) Run = 1'b1;
            tick();
            chk($sformatf("%s add%0d", tag, i), 32'(obs),
                32'(mval ? ((i == N - 1) ? E_SUB : E_ADD) : E_NOP));
            tick();
            chk($sformatf("%s shift%0d", tag, i), 32'(obs), 32'(E_SHF));
            ClearA_LoadB = 1'b0;
        end
        tick();
        chk({tag, " done"}, 32'(obs), 32'(E_DONE));
        tick();
        chk({tag, " done held"}, 32'(obs), 32'(E_DONE));
        Run = 1'b0;
        #1 chk({tag, " done run low"}, 32'(obs), 32'(E_DONE));
        tick();
        chk({tag, " back idle"}, 32'(obs), 32'(E_ZERO));
    endtask

    // Load multiplier, run with the datapath, check product and Busy length.
    task automatic dp_run(input string tag, input logic [7:0] mcand,
                          input logic [7:0] mplier, input logic [15:0] exp_ab,
                          input logic exp_x);
        int cycles;
        int busy_cnt;
        dp_mode      = 1'b1;
        sw           = mplier;
        ClearA_LoadB = 1'b1;
        tick();
        ClearA_LoadB = 1'b0;
        sw           = mcand;
        Run          = 1'b1;
        cycles       = 0;
        busy_cnt     = 0;
        while (Done !== 1'b1 && cycles < 60) begin
            tick();
            cycles++;
            if (Busy === 1'b1) busy_cnt++;
        end
        chk({tag, " done reached"}, 32'(Done), 32'(1));
        chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(1 + 2 * N));
        chk({tag, " product A:B"}, 32'({dp_a, dp_b}), 32'(exp_ab));
        chk({tag, " sign X"}, 32'(dp_x), 32'(exp_x));
        Run = 1'b0;
        tick();
        chk({tag, " idle after"}, 32'(obs), 32'(E_ZERO));
    endtask

    initial begin
        Reset        = 1'b0;
        Run          = 1'b1;
        ClearA_LoadB = 1'b1;
        dp_mode      = 1'b0;
        m_force      = 1'b1;
        sw           = 8'h00;

        // Reset held with load request asserted: outputs stay low.
        #3 chk("reset outputs", 32'(obs), 32'(E_ZERO));
        tick();
        chk("reset outputs clocked", 32'(obs), 32'(E_ZERO));
        ClearA_LoadB = 1'b0;
        Reset        = 1'b1;

        // Run held high through reset release: no start.
        tick();
        chk("run held after reset 0", 32'(obs), 32'(E_ZERO));
        tick();
        chk("run held after reset 1", 32'(obs), 32'(E_ZERO));

        // Load request for exactly 3 cycles.
        ClearA_LoadB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("load cycle %0d", i), 32'(obs), 32'(E_LOAD));
            tick();
        end
        ClearA_LoadB = 1'b0;
        #1 chk("load released", 32'(obs), 32'(E_ZERO));
        Run = 1'b0;
        tick();
        chk("idle run low", 32'(obs), 32'(E_ZERO));

        run_const("m1", 1'b1, 1'b0);
        run_const("m0", 1'b0, 1'b0);
        run_const("m1 disturbed", 1'b1, 1'b1);

        dp_run("7x-3", 8'h07, 8'hFD, 16'hFFEB, 1'b1);
        dp_run("-128x-128", 8'h80, 8'h80, 16'h4000, 1'b0);
        dp_run("-5x6", 8'hFB, 8'h06, 16'hFFE2, 1'b1);

        // Reset in the middle of an ADD with M=1.
        dp_mode = 1'b0;
        m_force = 1'b1;
        Run     = 1'b1;
        tick();
        chk("pre-reset clr", 32'(obs), 32'(E_CLR));
        tick();
        chk("pre-reset add", 32'(obs), 32'(E_ADD));
        Reset = 1'b0;
        #1 chk("async reset mid add", 32'(obs), 32'(E_ZERO));
        tick();
        chk("reset held", 32'(obs), 32'(E_ZERO));
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("no restart with run held %0d", i), 32'(obs), 32'(E_ZERO));
        end
        Run = 1'b0;
        tick();
        chk("idle before restart", 32'(obs), 32'(E_ZERO));
        run_const("restart", 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
